// File: rtl/color_bar_generator.sv
// Eight-bar colour test pattern source, four identical RGB888 pixels per beat, one frame per start_frame.
// Build option: define COLOR_BAR_ROTATE_EN to shift the bars left by one bar on every completed frame.
module color_bar_generator (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] video_width,
  input  logic [15:0] video_height,
  input  logic        start_frame,
  input  logic        ready,
  output logic        valid,
  output logic [23:0] pixel_0,
  output logic [23:0] pixel_1,
  output logic [23:0] pixel_2,
  output logic [23:0] pixel_3,
  output logic        line_end,
  output logic        frame_end,
  output logic        config_error
);

  // Stream handshake: a beat transfers on a clock edge where valid && ready; while valid && !ready
  // every output holds; valid stays high from the first beat to the frame_end transfer.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [15:0] bar_width_q, bar_width_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_q, bar_d;
  logic        valid_q, valid_d;
  logic [23:0] color_q, color_d;
  logic        line_end_q, line_end_d;
  logic        frame_end_q, frame_end_d;
  logic        config_error_q, config_error_d;
`ifdef COLOR_BAR_ROTATE_EN
  logic [2:0]  phase_q, phase_d;
`endif

  logic        dims_ok;
  logic        last_x;
  logic        last_beat;
  logic        xfer;
  logic [2:0]  phase_new;
  logic [15:0] nx, ny, ncnt;
  logic [2:0]  nbar;
  logic        nle;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d        = state_q;
    width_d        = width_q;
    height_d       = height_q;
    bar_width_d    = bar_width_q;
    x_d            = x_q;
    y_d            = y_q;
    bar_cnt_d      = bar_cnt_q;
    bar_d          = bar_q;
    valid_d        = valid_q;
    color_d        = color_q;
    line_end_d     = line_end_q;
    frame_end_d    = frame_end_q;
    config_error_d = 1'b0;

    dims_ok   = (video_width != 16'd0) && (video_width[4:0] == 5'd0) && (video_height != 16'd0);
    last_x    = (x_q == width_q - 16'd4);
    last_beat = last_x && (y_q == height_q - 16'd1);
    xfer      = valid_q && ready;

`ifdef COLOR_BAR_ROTATE_EN
    // Only a frame whose last beat actually transferred moves the phase; aborts leave it alone.
    phase_new = (xfer && last_beat) ? phase_q + 3'd1 : phase_q;
    phase_d   = phase_new;
`else
    phase_new = 3'd0;
`endif

    // Position of the beat following the one currently presented.
    nx   = x_q + 16'd4;
    ny   = y_q;
    nbar = bar_q;
    ncnt = bar_cnt_q + 16'd4;
    if (last_x) begin
      nx   = 16'd0;
      ny   = y_q + 16'd1;
      nbar = 3'd0;
      ncnt = 16'd0;
    end else if (bar_cnt_q == bar_width_q - 16'd4) begin
      nbar = bar_q + 3'd1;
      ncnt = 16'd0;
    end
    nle = (nx == width_q - 16'd4);

    if (start_frame) begin
      if (dims_ok) begin
        state_d     = ACTIVE;
        width_d     = video_width;
        height_d    = video_height;
        bar_width_d = {3'b000, video_width[15:3]};
        x_d         = 16'd0;
        y_d         = 16'd0;
        bar_cnt_d   = 16'd0;
        bar_d       = 3'd0;
        valid_d     = 1'b1;
        color_d     = bar_color(phase_new);
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;
      end else begin
        state_d        = IDLE;
        valid_d        = 1'b0;
        line_end_d     = 1'b0;
        frame_end_d    = 1'b0;
        config_error_d = 1'b1;
      end
    end else if (xfer) begin
      if (last_beat) begin
        state_d     = IDLE;
        valid_d     = 1'b0;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;
      end else begin
        x_d         = nx;
        y_d         = ny;
        bar_d       = nbar;
        bar_cnt_d   = ncnt;
        color_d     = bar_color(nbar + phase_new);
        line_end_d  = nle;
        frame_end_d = nle && (ny == height_q - 16'd1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      width_q        <= 16'd0;
      height_q       <= 16'd0;
      bar_width_q    <= 16'd0;
      x_q            <= 16'd0;
      y_q            <= 16'd0;
      bar_cnt_q      <= 16'd0;
      bar_q          <= 3'd0;
      valid_q        <= 1'b0;
      color_q        <= 24'd0;
      line_end_q     <= 1'b0;
      frame_end_q    <= 1'b0;
      config_error_q <= 1'b0;
`ifdef COLOR_BAR_ROTATE_EN
      phase_q        <= 3'd0;
`endif
    end else begin
      state_q        <= state_d;
      width_q        <= width_d;
      height_q       <= height_d;
      bar_width_q    <= bar_width_d;
      x_q            <= x_d;
      y_q            <= y_d;
      bar_cnt_q      <= bar_cnt_d;
      bar_q          <= bar_d;
      valid_q        <= valid_d;
      color_q        <= color_d;
      line_end_q     <= line_end_d;
      frame_end_q    <= frame_end_d;
      config_error_q <= config_error_d;
`ifdef COLOR_BAR_ROTATE_EN
      phase_q        <= phase_d;
`endif
    end
  end

  assign valid        = valid_q;
  assign pixel_0      = color_q;
  assign pixel_1      = color_q;
  assign pixel_2      = color_q;
  assign pixel_3      = color_q;
  assign line_end     = line_end_q;
  assign frame_end    = frame_end_q;
  assign config_error = config_error_q;

endmodule

// File: doc/color_bar_generator.md
# color_bar_generator

- Generates SMPTE-style eight-bar colour test video at four pixels per beat, one frame per `start_frame` request.
- Sits directly upstream of the HDMI source in the tx clock domain.
- Drives its valid/ready pixel stream and receives the sink's frame request and active-area dimensions.
- Used for bring-up of new resolutions and for link and scrambler checks without a framebuffer.

## Interface

Parameters:
- none. The geometry arrives on ports; the only build-time option is in Configuration.

Ports:
- `clock` input 1: tx pixel-beat clock.
- `reset` input 1: synchronous, active-high.
- `video_width` input 16: active pixels per line. Sampled on accepted `start_frame`.
- `video_height` input 16: active lines per frame. Sampled on accepted `start_frame`.
- `start_frame` input 1: single-cycle request from the sink to begin a frame.
- `ready` input 1: sink accepts the current beat.
- `valid` output 1: beat present.
- `pixel_0`..`pixel_3` output 24 each: RGB888, R[23:16] G[15:8] B[7:0]. `pixel_0` is the leftmost pixel of the beat.
- `line_end` output 1: beat is the last of its line.
- `frame_end` output 1: beat is the last of the frame.
- `config_error` output 1: one-cycle pulse when `start_frame` is rejected.

## Operation

States are IDLE and ACTIVE.

IDLE:
- On `start_frame`, sample the width and height.
- If width ≠ 0, width[4:0] = 0 and height ≠ 0: latch `bar_width = width >> 3` and go to ACTIVE at x = 0, y = 0.
- Otherwise: pulse `config_error` and stay in IDLE.

ACTIVE:
- A beat transfers on `valid && ready`.
- After each transfer, x advances by 4.
- At x = width − 4, x wraps to 0 and y increments.
- At y = height − 1 with x = width − 4, the transfer completes the frame; go to IDLE.

Bars:
- Bar index b = 0..7 comes from a bar counter and a within-bar beat counter; no divider.
- Colours for b = 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Width is a multiple of 32, so `bar_width` is a multiple of 4 and a beat never straddles two bars. All four pixels of a beat are identical.

Flags:
- `line_end` = 1 when x = width − 4.
- `frame_end` = `line_end` && y = height − 1.

`start_frame` while ACTIVE:
- Abort the current frame and restart at (0,0) with newly sampled dimensions.
- Dimensions are validated as in IDLE. If invalid: pulse `config_error` and go to IDLE.
- An aborted frame does not advance the rotation phase.

## Timing

Reset values:
- `valid` = 0, pixels = 0, `line_end` = 0, `frame_end` = 0, `config_error` = 0.
- State = IDLE, rotation phase = 0.

Latency and pulses:
- `start_frame` sampled at cycle n → `valid` = 1 with beat (0,0) at n+1.
- `config_error` is high for exactly cycle n+1.

Handshake:
- All outputs are registered.
- While `valid && !ready`, pixels and flags hold stable.
- The next beat appears the cycle after the transfer.
- Full rate is one beat per cycle with `ready` held high.
- `valid` never drops mid-frame except on reset or on an invalid-restart abort.

End of frame:
- The cycle after the `frame_end` transfer, `valid` = 0.
- A `start_frame` arriving in the same cycle as the final transfer is honoured: the new frame begins at the next cycle, back-to-back with no gap.

Counters and reset:
- Counters are 16-bit and wrap only as described.
- Reset mid-frame returns to IDLE at the next edge; no partial beat is emitted afterwards.

## Configuration

- `COLOR_BAR_ROTATE_EN` defined:
  - A 3-bit rotation phase increments, mod 8, on each completed (non-aborted) frame.
  - The displayed colour is colour[(b + phase) mod 8], so the bars shift left by one bar per frame.
- `COLOR_BAR_ROTATE_EN` undefined:
  - The phase register is absent and colour[b] is fixed.
  - Every frame is identical.

## Test plan

- Frame size and markers: width 1920, height 1080, `ready` = 1, one `start_frame` → exactly 518400 beats.
  - 1080 `line_end` pulses.
  - One `frame_end`, on the last beat.
  - `valid` low the following cycle.
- Bar boundaries: width 256, height 2 → each line is 64 beats.
  - Beats 0–7 are FFFFFF, beats 8–15 are FFFF00, …, beats 56–63 are 000000.
- Back-pressure: `ready` toggles randomly at 50% → pixel and flag outputs are unchanged on every stalled cycle; the beat sequence equals the `ready` = 1 run.
- Invalid dimensions: width 1000 (not a multiple of 32) → one-cycle `config_error`, `valid` stays 0.
  - Width 0 gives the same result.
  - Height 0 gives the same result.
- Abort and back-to-back: `start_frame` mid-frame at (320, 5) → next beat is (0,0).
  - `start_frame` coincident with the final transfer → beat (0,0) follows with no idle cycle.
- Rotation, with `COLOR_BAR_ROTATE_EN`: three completed frames of width 256, height 1.
  - First beat colours are FFFFFF, then FFFF00, then 00FFFF.
  - An aborted frame does not advance the phase.
  - Without the macro, all frames start at FFFFFF.
